// File: rtl/protocol_pkg.sv
// Shared constants for the sensor command protocol: response codes, command codes and TX state encoding.
// Pure declarations, no logic.
package protocol_pkg;

   localparam logic [7:0] RESP_ACK  = 8'hF0;
   localparam logic [7:0] RESP_NONE = 8'h00;

   localparam logic [7:0] CMD_READ_TEMP  = 8'h01;
   localparam logic [7:0] CMD_READ_HUM   = 8'h02;
   localparam logic [7:0] CMD_READ_PRESS = 8'h03;
   localparam logic [7:0] CMD_PING       = 8'h10;

   // Bits per two-byte 8N1 frame: 2 x (start + 8 data + stop)
   localparam int FRAME_BITS = 20;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/protocol_response_tx_baud_tick.sv
// Bit-time divider: free-running 0..CLKS_PER_BIT-1 counter, tick is a one-cycle pulse on wrap.
// Zero latency decode of the count; clear restarts the bit period and suppresses that cycle's tick.
module baud_tick #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/protocol_response_tx.sv
// Serialises response_code then response_data as two back-to-back 8N1 UART bytes on tx.
// tx falls one cycle after accept; send is taken only while ready, otherwise dropped (no queueing).
module protocol_response_tx
   import protocol_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       send,
   input  logic [7:0] response_code,
   input  logic [7:0] response_data,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       tx
);

   tx_state_e   state_q;
   logic [15:0] shift_q;
   logic [2:0]  bit_cnt_q;
   logic        byte_idx_q;
   logic        tx_q;
   logic        ready_q;
   logic        done_q;
   logic        accept;
   logic        tick;

   assign accept = send && ready_q;

   baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (accept),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         byte_idx_q <= 1'b0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  shift_q    <= {response_data, response_code};
                  bit_cnt_q  <= '0;
                  byte_idx_q <= 1'b0;
                  tx_q       <= 1'b0;
                  ready_q    <= 1'b0;
                  state_q    <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  tx_q      <= shift_q[0];
                  bit_cnt_q <= '0;
                  state_q   <= ST_DATA;
               end
            end
            ST_DATA: begin
               // Shifting on every data bit leaves the next byte at the LSB after bit 7
               if (tick) begin
                  shift_q <= {1'b0, shift_q[15:1]};
                  if (bit_cnt_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     tx_q      <= shift_q[1];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (!byte_idx_q) begin
                     byte_idx_q <= 1'b1;
                     tx_q       <= 1'b0;
                     state_q    <= ST_START;
                  end else begin
                     byte_idx_q <= 1'b0;
                     ready_q    <= 1'b1;
                     done_q     <= 1'b1;
                     state_q    <= ST_IDLE;
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx    = tx_q;
   assign ready = ready_q;
   assign busy  = ~ready_q;
   assign done  = done_q;

endmodule

// File: tb/tb_protocol_response_tx.sv
// Bench for protocol_response_tx: per-cycle comparison against a time-based frame model,
// plus mid-bit decoding of the recorded line for the directed scenarios.
module tb_protocol_response_tx;
   import protocol_pkg::*;

   localparam int N  = 4;
   localparam int FL = FRAME_BITS * N;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       send = 1'b0;
   logic [7:0] response_code = 8'h00;
   logic [7:0] response_data = 8'h00;
   logic       ready, busy, done, tx;

   int n_checks = 0;
   int n_fail   = 0;
   int done_seen = 0;

   // Model: a frame is a 20-bit line pattern played for N cycles per bit after the accept edge
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   int          m_el   = 0;
   logic [19:0] m_bits = '1;

   logic rec [0:511];
   int   rec_n = 0;

   protocol_response_tx #(.CLKS_PER_BIT(N)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .send          (send),
      .response_code (response_code),
      .response_data (response_data),
      .ready         (ready),
      .busy          (busy),
      .done          (done),
      .tx            (tx)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [19:0] frame_bits(input logic [7:0] code, input logic [7:0] data);
      return {1'b1, data, 1'b0, 1'b1, code, 1'b0};
   endfunction

   function automatic logic [7:0] dec(input int base);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = rec[base + (1 + b) * N + N / 2];
      return r;
   endfunction

   task automatic step();
      logic exp_tx;
      @(posedge clk);
      if (!reset_n) begin
         m_busy = 1'b0; m_done = 1'b0; m_el = 0;
      end else if (!m_busy && send) begin
         m_busy = 1'b1; m_done = 1'b0; m_el = 1;
         m_bits = frame_bits(response_code, response_data);
      end else if (m_busy) begin
         if (m_el == FL) begin
            m_busy = 1'b0; m_done = 1'b1;
         end else begin
            m_el++; m_done = 1'b0;
         end
      end else begin
         m_done = 1'b0;
      end
      #1;
      exp_tx = m_busy ? m_bits[(m_el - 1) / N] : 1'b1;
      check_eq("tx", 32'(tx), 32'(exp_tx));
      check_eq("ready", 32'(ready), 32'(!m_busy));
      check_eq("busy", 32'(busy), 32'(m_busy));
      check_eq("done", 32'(done), 32'(m_done));
      if (done === 1'b1) done_seen++;
      if (rec_n < 512) begin
         rec[rec_n] = tx;
         rec_n++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   initial begin
      int d0;
      int bcnt;
      int gap;

      // Reset held three cycles, then a quiet line
      reset_n = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      step();
      check_eq("rst_tx", 32'(tx), 32'd1);
      check_eq("rst_ready", 32'(ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      repeat (50) step();

      // Single frame with an ignored request ten cycles in
      d0 = done_seen;
      response_code = RESP_ACK; response_data = 8'h1A; send = 1'b1;
      rec_n = 0;
      step();
      bcnt = (busy === 1'b1) ? 1 : 0;
      for (int i = 1; i < FL; i++) begin
         if (i == 10) begin
            send = 1'b1; response_code = RESP_NONE; response_data = 8'h77;
         end else begin
            send = 1'b0;
         end
         step();
         if (busy === 1'b1) bcnt++;
      end
      send = 1'b0;
      repeat (10) step();
      check_eq("f1_busy_cycles", 32'(bcnt), 32'(FL));
      check_eq("f1_start", 32'(rec[N / 2]), 32'd0);
      check_eq("f1_code", 32'(dec(0)), 32'hF0);
      check_eq("f1_stop0", 32'(rec[9 * N + N / 2]), 32'd1);
      check_eq("f1_data", 32'(dec(10 * N)), 32'h1A);
      check_eq("f1_stop1", 32'(rec[19 * N + N / 2]), 32'd1);
      check_eq("f1_done_cnt", 32'(done_seen - d0), 32'd1);

      // Back-to-back with send held high
      response_code = RESP_ACK; response_data = 8'h55; send = 1'b1;
      rec_n = 0;
      step();
      response_code = RESP_NONE; response_data = 8'hAA;
      for (int i = 1; i <= 2 * FL + 1; i++) step();
      send = 1'b0;
      repeat (FL + 5) step();
      check_eq("b2b_code0", 32'(dec(0)), 32'hF0);
      check_eq("b2b_data0", 32'(dec(10 * N)), 32'h55);
      check_eq("b2b_code1", 32'(dec(FL + 1)), 32'h00);
      check_eq("b2b_data1", 32'(dec(FL + 1 + 10 * N)), 32'hAA);
      gap = 0;
      for (int j = 19 * N; j <= FL + 1; j++) begin
         if (rec[j] !== 1'b1) break;
         gap++;
      end
      check_eq("b2b_high_gap", 32'(gap), 32'(N + 1));

      // Reset during data bit 3 of the second byte
      response_code = RESP_ACK; response_data = 8'hC3; send = 1'b1;
      step();
      send = 1'b0;
      for (int i = 1; i <= 14 * N + 1; i++) step();
      d0 = done_seen;
      reset_n = 1'b0;
      step();
      check_eq("midrst_tx", 32'(tx), 32'd1);
      check_eq("midrst_ready", 32'(ready), 32'd1);
      reset_n = 1'b1;
      repeat (FL + 5) step();
      check_eq("midrst_no_done", 32'(done_seen - d0), 32'd0);
      response_code = 8'h81; response_data = 8'h5A; send = 1'b1;
      rec_n = 0;
      step();
      send = 1'b0;
      repeat (FL + 5) step();
      check_eq("midrst_code", 32'(dec(0)), 32'h81);
      check_eq("midrst_data", 32'(dec(10 * N)), 32'h5A);
      check_eq("midrst_done_cnt", 32'(done_seen - d0), 32'd1);

      // Inputs change right after accept
      response_code = RESP_ACK; response_data = 8'h3C; send = 1'b1;
      rec_n = 0;
      step();
      send = 1'b0; response_data = 8'hFF; response_code = 8'h00;
      repeat (FL + 3) step();
      check_eq("latch_code", 32'(dec(0)), 32'hF0);
      check_eq("latch_data", 32'(dec(10 * N)), 32'h3C);

      // Random traffic: sparse and held requests, changing inputs, occasional resets
      for (int i = 0; i < 3000; i++) begin
         reset_n       = ($urandom_range(0, 299) != 0);
         send          = (i % 600 < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 9) != 0);
         response_code = 8'($urandom);
         response_data = 8'($urandom);
         step();
      end
      reset_n = 1'b1;
      send = 1'b0;
      repeat (FL + 5) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/protocol_response_tx.md
# protocol_response_tx

Transmit side of the sensor command protocol. Takes a response code and data byte from the decoder/controller side and serialises them as a two-byte UART frame (code byte first, then data byte, each 8N1, LSB first) on the board TX pin. It is the counterpart of the byte receiver feeding `protocol_decoder`, and closes the command/response loop to the host PC.

## Interface
- `CLKS_PER_BIT`, 5208, clock cycles per UART bit (50 MHz / 9600 baud); legal range 2..65535
- `clk`  in  1  system clock, rising-edge
- `reset_n`  in  1  synchronous active-low reset
- `send`  in  1  request strobe; sampled only when `ready`=1
- `response_code`  in  8  first byte of frame (e.g. 0xF0 = command acknowledged, 0x00 = invalid command)
- `response_data`  in  8  second byte of frame (sensor payload)
- `ready`  out  1  high when idle and able to accept `send`
- `busy`  out  1  high while a frame is in flight (`busy` = ~`ready`)
- `done`  out  1  one-cycle pulse when the frame's final stop bit completes
- `tx`  out  1  serial line, idle high

## Operation
- Reset (`reset_n`=0 at a rising edge): `tx`=1, `ready`=1, `busy`=0, `done`=0. State goes to IDLE, bit counter = 0, byte index = 0, baud counter = 0. Reset mid-frame aborts immediately; `tx` is high on the next cycle and no `done` is issued.
- Accept: `send`=1 while `ready`=1 latches `response_code` and `response_data` into an internal 16-bit shift register. Inputs may change afterwards. `send` while `busy` is ignored, with no queueing.
- FSM states:
  - IDLE: `tx`=1.
  - START: `tx`=0 for one bit time.
  - DATA: 8 bit times, LSB first; bit counter 0..7.
  - STOP: `tx`=1 for one bit time.
- After STOP of byte 0, go to START with byte index 1.
- After STOP of byte 1, go to IDLE and pulse `done`.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs on wrap. The counter is cleared on accept so every bit is exactly CLKS_PER_BIT cycles.
- No parity, one stop bit, no inter-byte gap beyond the stop bit.

## Timing
- `tx` falls on the first rising edge after the accepting edge, i.e. one cycle of latency. `tx` is registered with no combinational path from inputs.
- Frame length is exactly 20 × CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle inclusive.
- `done`=1 and `ready`=1 on the cycle immediately after the last STOP cycle. The two rise on the same edge.
- Back-to-back: `send`=1 in that same cycle is accepted. The next START begins one cycle later, giving a total idle `tx`-high gap of 1 cycle beyond the stop bit.
- `send` held high continuously produces consecutive frames, each re-latching the current inputs at accept time.
- `done` never overlaps `busy`=1 of the same frame.

## Structure
- Shared package `protocol_pkg`:
  - response code constants `RESP_ACK`=8'hF0 and `RESP_NONE`=8'h00
  - command code constants shared with `protocol_decoder`
  - the TX state encoding (IDLE/START/DATA/STOP, 2 bits)
- One sub-module `baud_tick`:
  - parameter CLKS_PER_BIT
  - inputs `clk`, `reset_n`, `clear`
  - output `tick`, a one-cycle pulse on wrap
- The FSM, shift register and byte index live in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: hold `reset_n`=0 for 3 cycles, then release -> `tx`=1, `ready`=1, `busy`=0, `done`=0. No `tx` toggles for 50 cycles.
- Single frame: `send` pulse with code 0xF0, data 0x1A -> line sampled mid-bit reads 0,00001111,1,0,01011000,1. Exactly 80 cycles of `busy`, then a single `done` pulse.
- Ignored request: second `send` with code 0x00 issued 10 cycles into the frame -> frame content unchanged (0xF0/0x1A). Only one `done`.
- Back-to-back: `send` held high with code 0xF0/data 0x55, then 0x00/0xAA -> two frames separated by exactly one extra idle cycle. Decoded bytes are F0,55,00,AA.
- Reset mid-frame: assert `reset_n`=0 during DATA bit 3 of byte 1 -> `tx`=1 next cycle, `ready`=1, no `done`. A new `send` then produces a complete correct frame.
- Input change after accept: change `response_data` from 0x3C to 0xFF one cycle after accept -> transmitted data byte is 0x3C.
